// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage program counter.
// The next-PC source select is shared so the top and any debug logic agree on encodings.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_BRANCH,
        PC_SEL_TRAP,
        PC_SEL_RAS
    } pc_sel_e;

    localparam int          XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
// A simultaneous push and pop replaces the top entry in place.
module return_address_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] push_idx;
    logic [CNT_W-1:0] count;

    assign top      = entries[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign push_idx = pop ? top_ptr : top_ptr + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && !pop) begin
            top_ptr <= top_ptr + 1'b1;
            if (!full) count <= count + 1'b1;
        end else if (pop && !push) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    // Entry storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) entries[push_idx] <= push_addr;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch program counter with prioritised next-PC selection, RAS return prediction
// and a valid/ready request towards instruction memory.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            PCSrc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] program_counter,
    output logic [XLEN-1:0] pc_plus,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic            ras_empty,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    pc_sel_e         pc_sel;
    logic            fire;
    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] ras_top;

    assign fire    = fetch_valid & fetch_ready & ~stall;
    assign pc_plus = program_counter + XLEN'(INSTR_BYTES);

    // Trap and branch flush regardless of the handshake; a RAS return only on an accepted fetch.
    always_comb begin
        pc_sel          = PC_SEL_SEQ;
        redirect_target = pc_plus;
        if (trap_valid) begin
            pc_sel          = PC_SEL_TRAP;
            redirect_target = trap_vector;
        end else if (PCSrc) begin
            pc_sel          = PC_SEL_BRANCH;
            redirect_target = PCTarget;
        end else if (ras_pop && !ras_empty && fire) begin
            pc_sel          = PC_SEL_RAS;
            redirect_target = ras_top;
        end
    end

    assign redirect = (pc_sel != PC_SEL_SEQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            program_counter <= RESET_VECTOR;
            fetch_valid     <= 1'b0;
            misaligned      <= 1'b0;
        end else begin
            fetch_valid <= 1'b1;
            misaligned  <= redirect && ((redirect_target & ALIGN_MASK) != '0);
            if (redirect)
                program_counter <= redirect_target & ~ALIGN_MASK;
            else if (fire)
                program_counter <= pc_plus;
        end
    end

    return_address_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .push_addr (ras_push_addr),
        .pop       (pc_sel == PC_SEL_RAS),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      ()
    );

endmodule
